inv_rr_arbiter6: RTL and testbench

Round-robin arbiter that shares one six-way resource among six requesters. Its grant outputs are active-low and one-cold, in the same `b5..b0` style as the active-low 3-to-6 select decoder. It also publishes the 3-bit encoded index of the holder. It sits in front of the shared resource and has two jobs: no two requesters are ever selected at the same time, and no requester can hold the resource beyond a bounded number of cycles.

---
 rtl/inv_rr_arbiter6_if.sv | 25 ++
 rtl/inv_rr_arbiter6.sv | 120 ++++++++++++
 tb/tb_inv_rr_arbiter6.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/inv_rr_arbiter6_if.sv
// Request/grant bundle between six requesters and the round-robin arbiter.
// master: requester side (drives req_n); slave: arbiter side (drives grants).
interface inv_rr_arbiter6_if;
  logic [5:0] req_n;
  logic [5:0] gnt_n;
  logic [2:0] gnt_idx;
  logic       busy;
  logic       timeout;

  modport master (
    output req_n,
    input  gnt_n,
    input  gnt_idx,
    input  busy,
    input  timeout
  );

  modport slave (
    input  req_n,
    output gnt_n,
    output gnt_idx,
    output busy,
    output timeout
  );
endinterface

// File: rtl/inv_rr_arbiter6.sv
// Six-way round-robin arbiter, active-low one-cold grants, bounded hold.
// Ports: clk, rst_n (sync, active-low), arb (slave: req_n in;
// gnt_n, gnt_idx, busy, timeout out -- all registered).
module inv_rr_arbiter6 #(
  parameter int unsigned HOLD_MAX = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  inv_rr_arbiter6_if.slave   arb
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic [5:0] gnt_n_q, gnt_n_d;
  logic       busy_q, busy_d;
  logic       tmo_q, tmo_d;

  logic       win_vld;
  logic [2:0] win_idx;

  // Modulo-6 reduction; callers never pass more than 10.
  function automatic logic [2:0] wrap6(input logic [3:0] s);
    logic [3:0] r;
    r = (s >= 4'd6) ? (s - 4'd6) : s;
    return r[2:0];
  endfunction

  // Scan from ptr with wrap. Walking the offsets downward lets the
  // smallest offset (closest to ptr) win without a found flag.
  always_comb begin
    win_vld = 1'b0;
    win_idx = ptr_q;
    for (int k = 5; k >= 0; k--) begin
      if (!arb.req_n[wrap6({1'b0, ptr_q} + 4'(k))]) begin
        win_vld = 1'b1;
        win_idx = wrap6({1'b0, ptr_q} + 4'(k));
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
    unique case (state_q)
      S_GRANT: begin
        // Release wins over the hold limit on the same edge.
        if (arb.req_n[idx_q]) begin
          state_d = S_GAP;
          ptr_d   = wrap6({1'b0, idx_q} + 4'd1);
        end else if (cnt_q == HOLD_LIM) begin
          state_d = S_GAP;
          ptr_d   = wrap6({1'b0, idx_q} + 4'd1);
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_IDLE, S_GAP: begin
        if (win_vld) begin
          state_d = S_GRANT;
          idx_d   = win_idx;
          cnt_d   = 8'd1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs follow the next state so they come straight off flops.
  always_comb begin
    busy_d  = (state_d == S_GRANT);
    gnt_n_d = 6'h3f;
    if (busy_d) begin
      gnt_n_d = ~(6'b000001 << idx_d);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= 3'd0;
      idx_q   <= 3'd0;
      cnt_q   <= 8'd0;
      gnt_n_q <= 6'h3f;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      gnt_n_q <= gnt_n_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
    end
  end

  assign arb.gnt_n   = gnt_n_q;
  assign arb.gnt_idx = idx_q;
  assign arb.busy    = busy_q;
  assign arb.timeout = tmo_q;

endmodule

// File: tb/tb_inv_rr_arbiter6.sv
// Bench for inv_rr_arbiter6: four instances with different hold limits
// share one stimulus stream and are checked against a queue-free model.
module tb_inv_rr_arbiter6;
  localparam int NI = 4;
  localparam int HM [NI] = '{15, 4, 3, 2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [5:0] req_n;
  logic [5:0] gn [NI];
  logic [2:0] gi [NI];
  logic       bz [NI];
  logic       to [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    inv_rr_arbiter6_if u_if ();
    assign u_if.req_n = req_n;
    assign gn[g] = u_if.gnt_n;
    assign gi[g] = u_if.gnt_idx;
    assign bz[g] = u_if.busy;
    assign to[g] = u_if.timeout;
    inv_rr_arbiter6 #(.HOLD_MAX(HM[g])) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .arb   (u_if)
    );
  end

  // Model: who holds the resource (-1 none), how long, where to search
  // next, last holder, whether this is the dead cycle, timeout pulse.
  int m_hold [NI];
  int m_age  [NI];
  int m_ptr  [NI];
  int m_idx  [NI];
  bit m_gap  [NI];
  bit m_tmo  [NI];

  int checks = 0;
  int passes = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic model_step();
    for (int g = 0; g < NI; g++) begin
      if (!rst_n) begin
        m_hold[g] = -1; m_age[g] = 0; m_ptr[g] = 0;
        m_idx[g] = 0; m_gap[g] = 0; m_tmo[g] = 0;
      end else begin
        m_tmo[g] = 0;
        if (m_hold[g] >= 0) begin
          if (req_n[m_hold[g]] || m_age[g] == HM[g]) begin
            m_tmo[g] = !req_n[m_hold[g]];
            m_ptr[g] = (m_hold[g] + 1) % 6;
            m_hold[g] = -1;
            m_gap[g] = 1;
          end else begin
            m_age[g]++;
          end
        end else begin
          m_gap[g] = 0;
          for (int k = 0; k < 6; k++) begin
            if (!req_n[(m_ptr[g] + k) % 6]) begin
              m_hold[g] = (m_ptr[g] + k) % 6;
              m_idx[g] = m_hold[g];
              m_age[g] = 1;
              break;
            end
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [5:0] e;
    for (int g = 0; g < NI; g++) begin
      e = 6'h3f;
      if (m_hold[g] >= 0) e[m_hold[g]] = 1'b0;
      chk($sformatf("i%0d gnt_n", g), int'(gn[g]), int'(e));
      chk($sformatf("i%0d busy", g), int'(bz[g]), int'(m_hold[g] >= 0));
      chk($sformatf("i%0d timeout", g), int'(to[g]), int'(m_tmo[g]));
      if (m_hold[g] >= 0 || m_gap[g])
        chk($sformatf("i%0d gnt_idx", g), int'(gi[g]), m_idx[g]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_n = 6'h3f;
    tick();
    rst_n = 1'b1;
  endtask

  int order [$];
  int pulses;
  int busyc;
  logic prev;

  initial begin
    rst_n = 1'b0;
    req_n = 6'h00;
    tick();
    tick();
    for (int g = 0; g < NI; g++) begin
      chk("rst gnt_n", int'(gn[g]), 6'h3f);
      chk("rst busy", int'(bz[g]), 0);
      chk("rst timeout", int'(to[g]), 0);
      chk("rst gnt_idx", int'(gi[g]), 0);
    end
    rst_n = 1'b1;
    tick();
    chk("first grant idx", int'(gi[0]), 0);
    chk("first grant gnt_n", int'(gn[0]), 6'b111110);

    // Single requester 2, released after 3 cycles.
    do_reset();
    req_n = 6'b111011;
    tick();
    chk("single gnt_n", int'(gn[0]), 6'b111011);
    chk("single idx", int'(gi[0]), 2);
    chk("single busy", int'(bz[0]), 1);
    tick();
    tick();
    req_n = 6'h3f;
    tick();
    chk("single gap gnt_n", int'(gn[0]), 6'h3f);
    chk("single gap tmo", int'(to[0]), 0);
    chk("single gap idx", int'(gi[0]), 2);
    tick();
    chk("single idle busy", int'(bz[0]), 0);

    // Full rotation on the HOLD_MAX=4 instance.
    do_reset();
    req_n = 6'h00;
    prev = 1'b0;
    pulses = 0;
    busyc = 0;
    for (int c = 0; c < 35; c++) begin
      tick();
      if (bz[1] && !prev) order.push_back(int'(gi[1]));
      prev = bz[1];
      pulses += int'(to[1]);
      busyc += int'(bz[1]);
    end
    chk("rot grants", order.size(), 7);
    for (int i = 0; i < order.size() && i < 7; i++)
      chk($sformatf("rot order[%0d]", i), order[i], i % 6);
    chk("rot pulses", pulses, 7);
    chk("rot busy cycles", busyc, 28);

    // Pointer priority: after 3, both 1 and 5 pending -> 5 first.
    do_reset();
    req_n = 6'b110111;
    tick();
    chk("ptr grant3", int'(gi[0]), 3);
    tick();
    req_n = 6'b011101;
    tick();
    chk("ptr gap", int'(bz[0]), 0);
    tick();
    chk("ptr grant5", int'(gi[0]), 5);
    chk("ptr gnt5", int'(gn[0]), 6'b011111);
    req_n = 6'b111101;
    tick();
    tick();
    chk("ptr grant1", int'(gi[0]), 1);
    chk("ptr gnt1", int'(gn[0]), 6'b111101);

    // Release on the limit edge (HOLD_MAX=3): no pulse.
    do_reset();
    req_n = 6'b111110;
    tick(); tick(); tick();
    chk("lim3 busy", int'(bz[2]), 1);
    req_n = 6'h3f;
    tick();
    chk("lim3 rel busy", int'(bz[2]), 0);
    chk("lim3 rel tmo", int'(to[2]), 0);
    do_reset();
    req_n = 6'b111110;
    tick(); tick(); tick(); tick();
    chk("lim3 hold busy", int'(bz[2]), 0);
    chk("lim3 hold tmo", int'(to[2]), 1);

    // Reset mid-grant.
    do_reset();
    req_n = 6'b101111;
    tick();
    chk("mid grant4", int'(gi[0]), 4);
    req_n = 6'b101110;
    rst_n = 1'b0;
    tick();
    chk("mid rst gnt_n", int'(gn[0]), 6'h3f);
    chk("mid rst busy", int'(bz[0]), 0);
    rst_n = 1'b1;
    tick();
    chk("mid after idx", int'(gi[0]), 0);
    chk("mid after gnt_n", int'(gn[0]), 6'b111110);

    // Lone requester times out and is re-granted (HOLD_MAX=2).
    do_reset();
    req_n = 6'b111110;
    tick();
    chk("lone g1", int'(gn[3]), 6'b111110);
    tick();
    chk("lone g2", int'(bz[3]), 1);
    tick();
    chk("lone gap", int'(gn[3]), 6'h3f);
    chk("lone tmo", int'(to[3]), 1);
    tick();
    chk("lone regrant", int'(gn[3]), 6'b111110);
    chk("lone tmo off", int'(to[3]), 0);

    // Random traffic, occasional resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0) req_n = 6'($urandom);
      rst_n = ($urandom_range(249) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
